// File: rtl/inst_fetch_pkg.sv
// Shared CPU constants used by the fetch stage and the IF/ID register.
package cpu_defs;

    localparam int AddrLen  = 32;
    localparam int InstLen  = 32;
    localparam int StallLen = 2;

    localparam logic [StallLen-1:0] STALL_NONE     = 2'd0;
    localparam logic [StallLen-1:0] STALL_NEXT_ONE = 2'd1;
    localparam logic [StallLen-1:0] STALL_NEXT_TWO = 2'd2;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [2:0]  INST_BYTES = 3'd4;

    function automatic logic [AddrLen-1:0] word_align(input logic [AddrLen-1:0] addr);
        return {addr[AddrLen-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads
// and hands {pc, inst} pairs plus a stall code to the IF/ID register.
module inst_fetch
    import cpu_defs::*;
#(
    parameter logic [AddrLen-1:0] RESET_PC = ZERO_WORD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hold_in,
    input  logic                br_taken,
    input  logic [AddrLen-1:0]  br_target,
    output logic                mem_req,
    output logic [AddrLen-1:0]  mem_addr,
    input  logic                mem_grant,
    input  logic [7:0]          mem_rdata,
    output logic [AddrLen-1:0]  if_pc,
    output logic [InstLen-1:0]  if_inst,
    output logic [StallLen-1:0] stall_o
);

    logic [AddrLen-1:0]  pc_q, pc_d;
    logic [2:0]          issue_idx_q, issue_idx_d;
    logic [2:0]          rx_idx_q, rx_idx_d;
    logic                inflight_q, inflight_d;
    logic                tag_drop_q, tag_drop_d;
    logic [InstLen-1:0]  buf_q, buf_d;
    logic [AddrLen-1:0]  if_pc_q, if_pc_d;
    logic [InstLen-1:0]  if_inst_q, if_inst_d;
    logic [StallLen-1:0] stall_q, stall_d;

    logic               capture;
    logic               completing;
    logic               issue_open;
    logic               granted;
    logic [2:0]         rx_count;
    logic [AddrLen-1:0] issue_addr;

    // Completing an instruction also opens byte 0 of the next one at pc+4,
    // which is what sustains one instruction every four cycles.
    always_comb begin
        capture    = inflight_q && !tag_drop_q && !br_taken;
        rx_count   = rx_idx_q + {2'b00, capture};
        completing = !br_taken && !hold_in && (rx_count == INST_BYTES);
        issue_open = !rst && !br_taken && !hold_in &&
                     ((issue_idx_q < INST_BYTES) || completing);
        issue_addr = completing ? pc_q + AddrLen'(INST_BYTES)
                                : pc_q + AddrLen'(issue_idx_q);
        granted    = issue_open && mem_grant;

        buf_d = buf_q;
        if (capture) begin
            buf_d[{rx_idx_q[1:0], 3'b000} +: 8] = mem_rdata;
        end

        pc_d        = pc_q;
        issue_idx_d = issue_idx_q + {2'b00, granted};
        rx_idx_d    = rx_count;
        inflight_d  = granted;
        tag_drop_d  = 1'b0;
        if_pc_d     = if_pc_q;
        if_inst_d   = if_inst_q;
        stall_d     = hold_in ? stall_q : STALL_NEXT_ONE;

        // A redirect beats both completion and hold in the same cycle.
        if (br_taken) begin
            pc_d        = word_align(br_target);
            issue_idx_d = 3'd0;
            rx_idx_d    = 3'd0;
            buf_d       = ZERO_WORD;
            tag_drop_d  = inflight_q;
            stall_d     = STALL_NEXT_TWO;
        end else if (completing) begin
            if_pc_d     = pc_q;
            if_inst_d   = buf_d;
            stall_d     = STALL_NONE;
            pc_d        = pc_q + AddrLen'(INST_BYTES);
            issue_idx_d = {2'b00, granted};
            rx_idx_d    = 3'd0;
        end
    end

    assign mem_req  = issue_open;
    assign mem_addr = issue_open ? issue_addr : ZERO_WORD;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            issue_idx_q <= 3'd0;
            rx_idx_q    <= 3'd0;
            inflight_q  <= 1'b0;
            tag_drop_q  <= 1'b0;
            buf_q       <= ZERO_WORD;
            if_pc_q     <= ZERO_WORD;
            if_inst_q   <= ZERO_WORD;
            stall_q     <= STALL_NEXT_ONE;
        end else begin
            pc_q        <= pc_d;
            issue_idx_q <= issue_idx_d;
            rx_idx_q    <= rx_idx_d;
            inflight_q  <= inflight_d;
            tag_drop_q  <= tag_drop_d;
            buf_q       <= buf_d;
            if_pc_q     <= if_pc_d;
            if_inst_q   <= if_inst_d;
            stall_q     <= stall_d;
        end
    end

    assign if_pc   = if_pc_q;
    assign if_inst = if_inst_q;
    assign stall_o = stall_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: byte-memory model plus a queue of expected
// {pc, inst} deliveries that is drained whenever the DUT reports STALL_NONE.
module tb_inst_fetch;
    import cpu_defs::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold_in;
    logic        br_taken;
    logic [31:0] br_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_grant;
    logic [7:0]  mem_rdata = 8'h00;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [1:0]  stall_o;

    int    total = 0;
    int    bad = 0;
    logic  deliveredNow = 1'b0;
    logic  holdAtEdge = 1'b0;
    pair_t expQ[$];

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold_in   (hold_in),
        .br_taken  (br_taken),
        .br_target (br_target),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_grant (mem_grant),
        .mem_rdata (mem_rdata),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memByte(input logic [31:0] a);
        logic [7:0] v;
        case (a)
            32'h0:   v = 8'h13;
            32'h1:   v = 8'h05;
            32'h2:   v = 8'h00;
            32'h3:   v = 8'h00;
            default: v = (a[7:0] * 8'd37) ^ a[31:24] ^ 8'h5A;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {memByte(a + 32'd3), memByte(a + 32'd2), memByte(a + 32'd1), memByte(a)};
    endfunction

    // Byte memory: data for a granted request is valid for the following cycle only.
    always @(posedge clk) begin
        mem_rdata  <= (mem_req && mem_grant) ? memByte(mem_addr) : 8'hEE;
        holdAtEdge <= hold_in;
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic hold, input logic br, input logic [31:0] target,
                                 input logic grant);
        hold_in   = hold;
        br_taken  = br;
        br_target = target;
        mem_grant = grant;
    endtask

    task automatic tick();
        pair_t e;
        @(negedge clk);
        deliveredNow = 1'b0;
        if (rst === 1'b0 && stall_o === STALL_NONE && !holdAtEdge) begin
            deliveredNow = 1'b1;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_delivery", {32'h0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("deliver_pc", {32'h0, if_pc}, {32'h0, e.pc});
                checkOutput("deliver_inst", {32'h0, if_inst}, {32'h0, e.inst});
            end
        end
    endtask

    task automatic waitAddr(input logic [31:0] target, input string tag);
        int n;
        n = 0;
        #1;
        while (!(mem_req === 1'b1 && mem_addr === target) && n < 40) begin
            tick();
            #1;
            n++;
        end
        checkOutput(tag, {63'h0, (n < 40)}, 64'h1);
    endtask

    task automatic runUntilDelivery(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!deliveredNow && n < 40);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        tick();
        #1;
        checkOutput("reset_stall", {62'h0, stall_o}, {62'h0, STALL_NEXT_ONE});
        checkOutput("reset_if_pc", {32'h0, if_pc}, 64'h0);
        checkOutput("reset_if_inst", {32'h0, if_inst}, 64'h0);
        checkOutput("reset_req", {31'h0, mem_req, mem_addr}, 64'h0);

        // First fetch from RESET_PC with grants every cycle.
        rst = 1'b0;
        expQ.push_back('{32'h0, 32'h0000_0513});
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("first_addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'(i)});
            checkOutput("first_stall", {62'h0, stall_o}, {62'h0, STALL_NEXT_ONE});
            tick();
        end
        #1;
        checkOutput("next_issue_on_capture", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h4});
        checkOutput("no_early_delivery", {63'h0, deliveredNow}, 64'h0);
        tick();
        checkOutput("first_delivery_cycle6", {63'h0, deliveredNow}, 64'h1);

        // Back-to-back deliveries every fourth cycle.
        for (int k = 1; k <= 4; k++) begin
            expQ.push_back('{32'(4 * k), memWord(32'(4 * k))});
        end
        for (int k = 0; k < 3; k++) begin
            runUntilDelivery(n);
            checkOutput("b2b_spacing", 64'(n), 64'd4);
        end

        // Grant denied three times on byte 2 of the instruction at 0x10.
        waitAddr(32'h12, "reach_byte2");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            tick();
            #1;
            checkOutput("deny_hold_addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h12});
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        #1;
        checkOutput("deny_byte3_addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h13});
        tick();
        checkOutput("deny_not_yet", {63'h0, deliveredNow}, 64'h0);
        tick();
        checkOutput("deny_late_delivery", {63'h0, deliveredNow}, 64'h1);

        // Redirect to 0x102 while byte 1 of 0x14 is in flight.
        expQ.push_back('{32'h100, memWord(32'h100)});
        waitAddr(32'h16, "reach_byte2_of_14");
        applyStimulus(1'b0, 1'b1, 32'h102, 1'b1);
        #1;
        checkOutput("br_no_req", {63'h0, mem_req}, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("br_stall", {62'h0, stall_o}, {62'h0, STALL_NEXT_TWO});
        #1;
        checkOutput("br_first_addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h100});
        runUntilDelivery(n);
        checkOutput("br_latency", 64'(n), 64'd5);

        // Hold spanning the byte 3 capture of the instruction at 0x104.
        expQ.push_back('{32'h104, memWord(32'h104)});
        waitAddr(32'h107, "reach_byte3_of_104");
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        for (int j = 0; j < 5; j++) begin
            #1;
            checkOutput("hold_no_req", {63'h0, mem_req}, 64'h0);
            checkOutput("hold_if_pc", {32'h0, if_pc}, {32'h0, 32'h100});
            checkOutput("hold_if_inst", {32'h0, if_inst}, {32'h0, memWord(32'h100)});
            checkOutput("hold_stall", {62'h0, stall_o}, {62'h0, STALL_NEXT_ONE});
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("release_issue", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h108});
        checkOutput("release_not_yet", {63'h0, deliveredNow}, 64'h0);
        tick();
        checkOutput("release_delivery", {63'h0, deliveredNow}, 64'h1);

        // Redirect to the top word (low target bits ignored) and wrap to 0.
        expQ.push_back('{32'hFFFF_FFFC, memWord(32'hFFFF_FFFC)});
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFD, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        #1;
        checkOutput("top_first_addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
        waitAddr(32'hFFFF_FFFF, "reach_top_byte3");
        tick();
        #1;
        checkOutput("wrap_addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h0});
        tick();
        checkOutput("top_delivery", {63'h0, deliveredNow}, 64'h1);

        // Reset in the middle of fetching the instruction at 0.
        rst = 1'b1;
        #1;
        checkOutput("rst_no_req", {63'h0, mem_req}, 64'h0);
        tick();
        rst = 1'b0;
        checkOutput("rst_stall", {62'h0, stall_o}, {62'h0, STALL_NEXT_ONE});
        checkOutput("rst_if_pc", {32'h0, if_pc}, 64'h0);
        checkOutput("rst_if_inst", {32'h0, if_inst}, 64'h0);
        #1;
        checkOutput("rst_restart_addr", {31'h0, mem_req, mem_addr}, {31'h0, 1'b1, 32'h0});
        expQ.push_back('{32'h0, 32'h0000_0513});
        runUntilDelivery(n);
        checkOutput("rst_restart_latency", 64'(n), 64'd5);

        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the five-stage RISC-V core. Owns the PC, reads each 32-bit instruction as four little-endian bytes through the byte-wide instruction port of the memory controller, and presents completed `{pc, inst}` pairs plus a stall code to the IF/ID pipeline register. On cycles with no instruction to deliver it drives a bubble code. It accepts branch redirects from EX and a hold from the stall controller.

## Interface
- `RESET_PC`, default 32'h0: PC loaded on reset.
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: reset rst, synchronous, active-high.
- `hold_in`  in  1: downstream freeze; no new byte issues, delivered pair held.
- `br_taken`  in  1: redirect request from EX, single-cycle pulse.
- `br_target`  in  `AddrLen`: redirect PC; bits [1:0] ignored (treated as 0).
- `mem_req`  out  1: byte read request.
- `mem_addr`  out  `AddrLen`: byte address of request.
- `mem_grant`  in  1: request accepted this cycle (arbiter may deny for data port).
- `mem_rdata`  in  8: read byte, valid exactly one cycle after a granted request.
- `if_pc`  out  `AddrLen`: PC of delivered instruction.
- `if_inst`  out  `InstLen`: delivered instruction.
- `stall_o`  out  `StallLen`: stall code to IF/ID.

## Operation
- State: `pc` (current fetch address), `issue_idx` 0..4 (bytes granted for current instruction), `rx_idx` 0..4 (bytes captured), `inflight` (granted last cycle, data due now), `buf[31:0]`, `tag_drop` (discard in-flight byte).
- Issue: while `issue_idx < 4`, `!hold_in`, `!br_taken`: `mem_req=1`, `mem_addr = pc + issue_idx`. Grant increments `issue_idx`; denied request is re-presented unchanged next cycle.
- Capture: when `inflight`, `mem_rdata` written to `buf[8*rx_idx +: 8]`, `rx_idx++`; capture happens even under `hold_in`.
- Completion (`rx_idx` reaches 4, i.e. byte 3 captured): if `!hold_in`: `if_pc<=pc`, `if_inst<={byte3,byte2,byte1,byte0}`, `stall_o<=STALL_NONE`, `pc<=pc+4`, indices cleared. Byte 0 of next instruction is issued in the same cycle byte 3 is captured (address `pc+4`), so steady-state throughput is one instruction per 4 cycles.
- Completion under `hold_in`: instruction parked in `buf` with `rx_idx==4`; delivered the first cycle `hold_in` drops.
- Non-delivery cycles: `stall_o<=STALL_NEXT_ONE`, `if_pc`/`if_inst` keep last values.
- Redirect (`br_taken`): `pc<=br_target & ~3`, indices cleared, partial `buf` discarded, `tag_drop` set if a byte is in flight (that byte is ignored next cycle), no request issued this cycle, `stall_o<=STALL_NEXT_TWO`. Redirect wins over completion and over `hold_in` in the same cycle.
- PC arithmetic modulo 2^32; `pc+4` from 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: `pc=RESET_PC`, indices 0, `inflight=0`, `tag_drop=0`, `mem_req=0`, `mem_addr=0`, `if_pc=0`, `if_inst=0`, `stall_o=STALL_NEXT_ONE`.
- First request: cycle after `rst` deasserts. With grants every cycle: requests at t..t+3, bytes at t+1..t+4, `stall_o=STALL_NONE` with pair visible at t+5.
- Each denied grant adds exactly one cycle of latency.
- First request after redirect: cycle following `br_taken`.
- `rst` mid-fetch: all state to reset values next edge; in-flight byte discarded.
- `hold_in` only blocks issue and delivery; outputs do not change while held.

## Structure
- Shared package `cpu_defs`: `AddrLen`=32, `InstLen`=32, `StallLen`=2, `STALL_NONE`=2'd0, `STALL_NEXT_ONE`=2'd1, `STALL_NEXT_TWO`=2'd2, `ZERO_WORD`. IF/ID consumes the same constants.
- Single module; no sub-module. Issue/capture counters and the assembly buffer are inline.

## Test plan
- Reset, `RESET_PC`=0, memory 0..3 = 13,05,00,00, grant always -> `mem_addr` 0,1,2,3 on cycles 1-4; cycle 6 `if_pc`=0, `if_inst`=32'h00000513, `stall_o`=0; other cycles `stall_o`=1.
- Back-to-back fetch, grant always -> `stall_o`=0 every 4th cycle, `if_pc` 0,4,8,C.
- Deny grant on byte 2 for 3 cycles -> `mem_addr`=2 held 4 cycles; delivery 3 cycles late, `if_inst` unchanged.
- `br_taken` with `br_target`=32'h102 while byte 1 in flight -> byte dropped, `stall_o`=2, next `mem_addr`=32'h100, delivered `if_pc`=32'h100.
- `hold_in` high across byte 3 capture for 5 cycles -> no `mem_req`, outputs frozen, pair delivered cycle after release.
- `pc`=32'hFFFFFFFC fetch completes -> next `mem_addr`=0; `rst` mid-fetch -> all outputs reset values, restart at `RESET_PC`.
